spram_wb_ctrl: RTL
==================

// Module: spram_wb_ctrl
// PURPOSE
//  Wishbone-classic target driving the single-port byte-enable SRAM port
//  (adr/dat_i/dat_o/we/sel). Initiator side of the spram_32x256 interface:
//  converts bus cycles into SRAM accesses and clears the array after reset
//  or on request. Sits between the firmware-payload bus interconnect and an
//  spram instance.
// PARAMETERS
//  ADDR_BITS      8             SRAM word-address width; DEPTH = 2**ADDR_BITS
//  DATA_BITS      32            data width; SEL_BITS = DATA_BITS/8
//  INIT_ON_RESET  1             1: run INIT after reset; 0: go straight to IDLE
//  INIT_VALUE     32'h0000_0000 word written to every location during INIT
// PORTS
//  clock        in   1          single clock, all logic rising-edge
//  reset        in   1          synchronous, active-high
//  wb_adr_i     in   ADDR_BITS+2  byte address; word = wb_adr_i[ADDR_BITS+1:2]
//  wb_dat_i     in   DATA_BITS  write data
//  wb_dat_o     out  DATA_BITS  read data, valid only while wb_ack_o on a read
//  wb_sel_i     in   SEL_BITS   byte lanes
//  wb_we_i      in   1          1 = write
//  wb_cyc_i     in   1          bus cycle
//  wb_stb_i     in   1          strobe
//  wb_ack_o     out  1          single-cycle acknowledge
//  init_req_i   in   1          pulse: re-clear array (sampled in IDLE only)
//  init_done_o  out  1          1 = array usable, bus requests accepted
//  mem_adr_o    out  ADDR_BITS  to SRAM a_adr
//  mem_dat_o    out  DATA_BITS  to SRAM a_dat_i
//  mem_dat_i    in   DATA_BITS  from SRAM a_dat_o (registered read, 1-cycle)
//  mem_we_o     out  1          to SRAM a_we
//  mem_sel_o    out  SEL_BITS   to SRAM a_sel
// BEHAVIOUR
//  - SRAM contract: write commits at edge where we=1; read data on mem_dat_i
//    in the cycle after the address is presented.
//  - FSM states: INIT, IDLE, ACK. After reset: INIT if INIT_ON_RESET else IDLE.
//  - Reset values (cycle after reset edge): wb_ack_o=0, wb_dat_o=0,
//    init_done_o=0 (INIT_ON_RESET=1) / 1 (=0), init counter=0, mem_we_o per state.
//  - INIT: mem_adr_o=cnt, mem_dat_o=INIT_VALUE, mem_sel_o=all 1s, mem_we_o=1;
//    cnt increments each cycle; at cnt=DEPTH-1 -> IDLE, init_done_o=1 next
//    cycle. INIT takes exactly DEPTH cycles. Bus requests stall (no ack).
//  - IDLE: mem_adr_o=word(wb_adr_i), mem_dat_o=wb_dat_i, mem_sel_o=wb_sel_i,
//    mem_we_o=wb_cyc_i&wb_stb_i&wb_we_i. On cyc&stb -> ACK, latch rd=!wb_we_i.
//    init_req_i=1 in IDLE has priority over a concurrent request: -> INIT,
//    cnt=0, init_done_o=0; the request is served after INIT completes.
//  - ACK: wb_ack_o=wb_cyc_i (one cycle); wb_dat_o=mem_dat_i if rd else 0;
//    mem_we_o=0. Always -> IDLE. Latency: ack in cycle N+1 for request
//    presented in N, reads and writes alike. Back-to-back: next request
//    accepted in N+2 (master holds stb -> re-accepted, 2 cycles/access).
//  - cyc dropped in ACK: no ack, no side effect beyond an already-committed
//    write; return to IDLE.
//  - init_req_i ignored outside IDLE. Reset in any state (incl. mid-INIT)
//    restarts per INIT_ON_RESET; INIT always begins at cnt=0.
//  - cnt is ADDR_BITS wide; no wrap past DEPTH-1 (terminates INIT).
// TESTING
//  1 reset, INIT_ON_RESET=1, ADDR_BITS=8 -> init_done_o rises 257 cycles after
//    reset release (256 writes + 1); read 0x3FC returns 0x00000000.
//  2 write 0xDEADBEEF sel 4'hF @0x010, then read @0x010 -> ack 1 cycle after
//    each stb, wb_dat_o=0xDEADBEEF during read ack; ack width 1 cycle.
//  3 word 0x11223344 @0x020, write 0x0000AB00 sel 4'b0010 -> read 0x1122AB44.
//  4 read request held from reset release -> no ack until init_done_o=1,
//    then ack 1 cycle later with INIT_VALUE.
//  5 reset asserted at cnt=100 during INIT -> INIT restarts at mem_adr_o=0,
//    full 256-cycle sequence; init_req_i pulse with concurrent write in IDLE
//    -> INIT first, write acked after done, read back shows written value.
//  6 cyc dropped during ACK -> wb_ack_o stays 0, FSM IDLE next cycle; stb held
//    across 4 reads -> acks every 2nd cycle, correct data each.

Source files
------------

// File: rtl/spram_wb_ctrl.sv
// Wishbone-classic target for a single-port byte-enable SRAM.
// Converts bus cycles to SRAM accesses and clears the array after reset.
//
// Ports:
//   clock, reset       single rising-edge clock, synchronous active-high reset
//   wb_adr_i           byte address; word index is wb_adr_i[ADDR_BITS+1:2]
//   wb_dat_i/wb_dat_o  write data in / read data out (valid while ack on read)
//   wb_sel_i           byte lanes
//   wb_we_i            1 = write
//   wb_cyc_i/wb_stb_i  bus cycle / strobe
//   wb_ack_o           single-cycle acknowledge
//   init_req_i         request a re-clear of the array (honoured in IDLE)
//   init_done_o        array usable, bus requests accepted
//   mem_*              SRAM port: address, write data, read data, we, sel
module spram_wb_ctrl #(
    parameter int                   ADDR_BITS     = 8,
    parameter int                   DATA_BITS     = 32,
    parameter bit                   INIT_ON_RESET = 1'b1,
    parameter logic [DATA_BITS-1:0] INIT_VALUE    = '0
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [ADDR_BITS+1:0]   wb_adr_i,
    input  logic [DATA_BITS-1:0]   wb_dat_i,
    output logic [DATA_BITS-1:0]   wb_dat_o,
    input  logic [DATA_BITS/8-1:0] wb_sel_i,
    input  logic                   wb_we_i,
    input  logic                   wb_cyc_i,
    input  logic                   wb_stb_i,
    output logic                   wb_ack_o,
    input  logic                   init_req_i,
    output logic                   init_done_o,
    output logic [ADDR_BITS-1:0]   mem_adr_o,
    output logic [DATA_BITS-1:0]   mem_dat_o,
    input  logic [DATA_BITS-1:0]   mem_dat_i,
    output logic                   mem_we_o,
    output logic [DATA_BITS/8-1:0] mem_sel_o
);

    localparam int SEL_BITS = DATA_BITS / 8;
    localparam logic [ADDR_BITS-1:0] LAST_ADR = '1;

    typedef enum logic [1:0] {
        ST_INIT,
        ST_IDLE,
        ST_ACK
    } state_t;

    state_t               state;
    state_t               state_next;
    logic [ADDR_BITS-1:0] cnt;
    logic [ADDR_BITS-1:0] cnt_next;
    logic                 rd;
    logic                 rd_next;
    logic                 done;
    logic                 done_next;

    logic                 req;
    logic [ADDR_BITS-1:0] word;
    logic                 unused_lsbs;

    assign req         = wb_cyc_i & wb_stb_i;
    assign word        = wb_adr_i[ADDR_BITS+1:2];
    // Byte offset within a word carries no meaning for a word-wide SRAM.
    assign unused_lsbs = ^wb_adr_i[1:0];
    assign init_done_o = done;

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= INIT_ON_RESET ? ST_INIT : ST_IDLE;
            cnt   <= '0;
            rd    <= 1'b0;
            done  <= !INIT_ON_RESET;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            rd    <= rd_next;
            done  <= done_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        rd_next    = rd;
        done_next  = done;
        mem_adr_o  = word;
        mem_dat_o  = wb_dat_i;
        mem_sel_o  = wb_sel_i;
        mem_we_o   = 1'b0;
        wb_ack_o   = 1'b0;
        wb_dat_o   = '0;

        unique case (state)
            ST_INIT: begin
                mem_adr_o = cnt;
                mem_dat_o = INIT_VALUE;
                mem_sel_o = {SEL_BITS{1'b1}};
                mem_we_o  = 1'b1;
                // Counter parks at the last address; INIT ends there.
                if (cnt == LAST_ADR) begin
                    state_next = ST_IDLE;
                    done_next  = 1'b1;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            ST_IDLE: begin
                // A write commits at the accepting edge; ack follows.
                mem_we_o = req & wb_we_i;
                if (init_req_i) begin
                    state_next = ST_INIT;
                    cnt_next   = '0;
                    done_next  = 1'b0;
                end else if (req) begin
                    state_next = ST_ACK;
                    rd_next    = !wb_we_i;
                end
            end
            ST_ACK: begin
                // SRAM read data lands in this cycle (registered read).
                wb_ack_o   = wb_cyc_i;
                wb_dat_o   = rd ? mem_dat_i : '0;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

endmodule
